// File: rtl/mlp_seq_classifier.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : mlp_seq_classifier
// Description : Time-multiplexed two-layer fixed-point MLP classifier. A single
//               signed MAC is shared across every hidden and output neuron.
//               Pixels and weights/biases come from external synchronous
//               memories (1-cycle read latency). Hidden activations are held in
//               an internal buffer. An iterative argmax produces the result.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   start        begin one classification (honoured only in IDLE)
//   in_addr      input-buffer read address
//   in_data      signed pixel, valid the cycle after in_addr
//   w_addr       weight-memory read address
//   w_data       signed weight/bias, valid the cycle after w_addr
//   busy         high from start acceptance through the done cycle
//   done         one-cycle completion pulse
//   class_idx    winning class index
//   class_score  winning class score
//
// Revision    : 1.0 - initial release
// ============================================================================
module mlp_seq_classifier #(
    parameter int IN_SIZE = 784,
    parameter int HID_N   = 10,
    parameter int OUT_N   = 10,
    parameter int DW      = 16,
    parameter int FRAC    = 8,
    parameter int ACC_W   = 40
) (
    input  logic                                                   clk,
    input  logic                                                   rst_n,
    input  logic                                                   start,
    output logic [$clog2(IN_SIZE)-1:0]                             in_addr,
    input  logic signed [DW-1:0]                                   in_data,
    output logic [$clog2(HID_N*(IN_SIZE+1)+OUT_N*(HID_N+1))-1:0]   w_addr,
    input  logic signed [DW-1:0]                                   w_data,
    output logic                                                   busy,
    output logic                                                   done,
    output logic [$clog2(OUT_N)-1:0]                               class_idx,
    output logic signed [DW-1:0]                                   class_score
);

    localparam int c_iaw  = $clog2(IN_SIZE);
    localparam int c_waw  = $clog2(HID_N*(IN_SIZE+1)+OUT_N*(HID_N+1));
    localparam int c_ow   = $clog2(OUT_N);
    // Per-neuron input counter must reach N (the bias slot) for either layer.
    localparam int c_cmax = (IN_SIZE > HID_N) ? IN_SIZE : HID_N;
    localparam int c_cw   = $clog2(c_cmax + 1);
    localparam int c_nmax = (HID_N > OUT_N) ? HID_N : OUT_N;
    localparam int c_nw   = $clog2(c_nmax + 1);

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_H_MAC   = 4'd1,
        S_H_DRAIN = 4'd2,
        S_H_WB    = 4'd3,
        S_O_MAC   = 4'd4,
        S_O_DRAIN = 4'd5,
        S_O_WB    = 4'd6,
        S_ARGMAX  = 4'd7,
        S_DONE    = 4'd8
    } state_t;

    state_t                      state_q, state_d;
    logic [c_cw-1:0]             cnt_q, cnt_d;
    logic [c_nw-1:0]             nidx_q, nidx_d;
    logic [c_ow-1:0]             aidx_q, aidx_d;
    logic signed [ACC_W-1:0]     acc_q, acc_d;
    logic [c_iaw-1:0]            in_addr_q, in_addr_d;
    logic [c_waw-1:0]            w_addr_q, w_addr_d;
    logic                        busy_q, busy_d;
    logic                        done_q, done_d;
    logic [c_ow-1:0]             class_idx_q, class_idx_d;
    logic signed [DW-1:0]        class_score_q, class_score_d;
    logic [c_ow-1:0]             best_idx_q, best_idx_d;
    logic signed [DW-1:0]        best_score_q, best_score_d;
    logic signed [DW-1:0]        hid_buf_q [HID_N];
    logic signed [DW-1:0]        hid_buf_d [HID_N];
    logic signed [DW-1:0]        score_q [OUT_N];
    logic signed [DW-1:0]        score_d [OUT_N];

    logic signed [DW-1:0]        hid_op;
    logic signed [DW-1:0]        mac_x;
    logic signed [2*DW-1:0]      prod;
    logic signed [ACC_W-1:0]     prod_ext;
    logic signed [ACC_W-1:0]     bias_ext;
    logic signed [DW-1:0]        wb_val;
    logic signed [DW-1:0]        cand_score;
    logic                        cand_better;

    // Arithmetic right shift by FRAC, then clamp to signed DW.
    function automatic logic signed [DW-1:0] sat_shift(input logic signed [ACC_W-1:0] a);
        logic signed [ACC_W-1:0] s;
        logic [ACC_W-DW:0]       hi;
        s  = a >>> FRAC;
        hi = s[ACC_W-1:DW-1];
        if ((&hi) || (~|hi)) begin
            return s[DW-1:0];
        end else if (s[ACC_W-1]) begin
            return {1'b1, {(DW-1){1'b0}}};
        end else begin
            return {1'b0, {(DW-1){1'b1}}};
        end
    endfunction

    // Operand/score muxes. In MAC cycle k (k>=1) the returning data belongs
    // to the address issued in cycle k-1, hence the hidden index cnt-1.
    always_comb begin
        hid_op = '0;
        for (int j = 0; j < HID_N; j++) begin
            if (cnt_q == c_cw'(j + 1)) begin
                hid_op = hid_buf_q[j];
            end
        end
        cand_score = '0;
        for (int j = 0; j < OUT_N; j++) begin
            if (aidx_q == c_ow'(j)) begin
                cand_score = score_q[j];
            end
        end
    end

    assign mac_x       = (state_q == S_H_MAC) ? in_data : hid_op;
    assign prod        = mac_x * w_data;
    assign prod_ext    = {{(ACC_W-2*DW){prod[2*DW-1]}}, prod};
    assign bias_ext    = {{(ACC_W-DW-FRAC){w_data[DW-1]}}, w_data, {FRAC{1'b0}}};
    assign wb_val      = sat_shift(acc_q);
    // Strict greater-than keeps the lowest index on ties.
    assign cand_better = (aidx_q == '0) || (cand_score > best_score_q);

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        nidx_d        = nidx_q;
        aidx_d        = aidx_q;
        acc_d         = acc_q;
        in_addr_d     = in_addr_q;
        w_addr_d      = w_addr_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        class_idx_d   = class_idx_q;
        class_score_d = class_score_q;
        best_idx_d    = best_idx_q;
        best_score_d  = best_score_q;
        hid_buf_d     = hid_buf_q;
        score_d       = score_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_H_MAC;
                    cnt_d   = '0;
                    nidx_d  = '0;
                    busy_d  = 1'b1;
                end
            end
            S_H_MAC: begin
                acc_d = (cnt_q == '0) ? '0 : acc_q + prod_ext;
                if (cnt_q == c_cw'(IN_SIZE)) begin
                    state_d = S_H_DRAIN;
                end else begin
                    cnt_d = cnt_q + c_cw'(1);
                end
            end
            S_H_DRAIN: begin
                acc_d   = acc_q + bias_ext;
                state_d = S_H_WB;
            end
            S_H_WB: begin
                for (int j = 0; j < HID_N; j++) begin
                    if (nidx_q == c_nw'(j)) begin
                        hid_buf_d[j] = wb_val[DW-1] ? '0 : wb_val;
                    end
                end
                cnt_d = '0;
                if (nidx_q == c_nw'(HID_N - 1)) begin
                    nidx_d  = '0;
                    state_d = S_O_MAC;
                end else begin
                    nidx_d  = nidx_q + c_nw'(1);
                    state_d = S_H_MAC;
                end
            end
            S_O_MAC: begin
                acc_d = (cnt_q == '0) ? '0 : acc_q + prod_ext;
                if (cnt_q == c_cw'(HID_N)) begin
                    state_d = S_O_DRAIN;
                end else begin
                    cnt_d = cnt_q + c_cw'(1);
                end
            end
            S_O_DRAIN: begin
                acc_d   = acc_q + bias_ext;
                state_d = S_O_WB;
            end
            S_O_WB: begin
                for (int j = 0; j < OUT_N; j++) begin
                    if (nidx_q == c_nw'(j)) begin
                        score_d[j] = wb_val;
                    end
                end
                cnt_d = '0;
                if (nidx_q == c_nw'(OUT_N - 1)) begin
                    nidx_d  = '0;
                    aidx_d  = '0;
                    state_d = S_ARGMAX;
                end else begin
                    nidx_d  = nidx_q + c_nw'(1);
                    state_d = S_O_MAC;
                end
            end
            S_ARGMAX: begin
                if (cand_better) begin
                    best_idx_d   = aidx_q;
                    best_score_d = cand_score;
                end
                if (aidx_q == c_ow'(OUT_N - 1)) begin
                    state_d       = S_DONE;
                    done_d        = 1'b1;
                    class_idx_d   = cand_better ? aidx_q : best_idx_q;
                    class_score_d = cand_better ? cand_score : best_score_q;
                end else begin
                    aidx_d = aidx_q + c_ow'(1);
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase

        // Addresses are registered, so they are computed for the cycle about
        // to be entered. Weight addresses are contiguous across all neurons
        // of both layers, so w_addr simply advances on every MAC cycle.
        if ((state_d == S_H_MAC) || (state_d == S_O_MAC)) begin
            w_addr_d = (state_q == S_IDLE) ? '0 : w_addr_q + c_waw'(1);
            if ((state_d == S_H_MAC) && (cnt_d < c_cw'(IN_SIZE))) begin
                in_addr_d = cnt_d[c_iaw-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            nidx_q        <= '0;
            aidx_q        <= '0;
            acc_q         <= '0;
            in_addr_q     <= '0;
            w_addr_q      <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            class_idx_q   <= '0;
            class_score_q <= '0;
            best_idx_q    <= '0;
            best_score_q  <= '0;
            for (int j = 0; j < HID_N; j++) begin
                hid_buf_q[j] <= '0;
            end
            for (int j = 0; j < OUT_N; j++) begin
                score_q[j] <= '0;
            end
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            nidx_q        <= nidx_d;
            aidx_q        <= aidx_d;
            acc_q         <= acc_d;
            in_addr_q     <= in_addr_d;
            w_addr_q      <= w_addr_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            class_idx_q   <= class_idx_d;
            class_score_q <= class_score_d;
            best_idx_q    <= best_idx_d;
            best_score_q  <= best_score_d;
            hid_buf_q     <= hid_buf_d;
            score_q       <= score_d;
        end
    end

    assign in_addr     = in_addr_q;
    assign w_addr      = w_addr_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign class_idx   = class_idx_q;
    assign class_score = class_score_q;

endmodule
`default_nettype wire

// File: tb/tb_mlp_seq_classifier.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_mlp_seq_classifier
// Description : Directed self-checking bench for mlp_seq_classifier with a
//               small network (4 inputs, 3 hidden, 3 classes, Q8.8).
//               Synchronous input/weight memories are modelled here.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mlp_seq_classifier;

    localparam int IN_SIZE = 4;
    localparam int HID_N   = 3;
    localparam int OUT_N   = 3;
    localparam int DW      = 16;
    localparam int LAT     = 43;
    localparam int OB      = HID_N * (IN_SIZE + 1);

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  in_addr;
    logic [15:0] in_data;
    logic [4:0]  w_addr;
    logic [15:0] w_data;
    logic        busy;
    logic        done;
    logic [1:0]  class_idx;
    logic [15:0] class_score;

    logic [15:0] in_mem [4];
    logic [15:0] w_mem  [32];

    int checks;
    int errors;

    mlp_seq_classifier #(
        .IN_SIZE (IN_SIZE),
        .HID_N   (HID_N),
        .OUT_N   (OUT_N),
        .DW      (DW),
        .FRAC    (8),
        .ACC_W   (40)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .in_addr     (in_addr),
        .in_data     (in_data),
        .w_addr      (w_addr),
        .w_data      (w_data),
        .busy        (busy),
        .done        (done),
        .class_idx   (class_idx),
        .class_score (class_score)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External synchronous memories: one-cycle read latency.
    always @(posedge clk) begin
        in_data <= in_mem[in_addr];
        w_data  <= w_mem[w_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 4; i++) in_mem[i] = 16'h0000;
        for (int i = 0; i < 32; i++) w_mem[i] = 16'h0000;
    endtask

    function automatic int hw(input int h, input int i);
        return h * (IN_SIZE + 1) + i;
    endfunction

    function automatic int ow(input int o, input int j);
        return OB + o * (HID_N + 1) + j;
    endfunction

    // Pulses start, then watches cycle by cycle (cycle 1 = first after the
    // accepting edge). Optionally re-asserts start at cycle inj_cyc and on
    // the done cycle. Returns done latency (-1 on timeout) and busy cycles.
    task automatic run(input int inj_cyc, input bit inj_done,
                       output int lat, output int busy_cnt);
        int  n;
        bit  seen;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        n        = 1;
        lat      = -1;
        busy_cnt = 0;
        seen     = 1'b0;
        while ((n <= 200) && !seen) begin
            if (busy) busy_cnt++;
            if (done) begin
                seen = 1'b1;
                lat  = n;
                if (inj_done) start = 1'b1;
            end else if (n == inj_cyc) begin
                start = 1'b1;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            n++;
        end
    endtask

    task automatic run_and_check(input string tag, input int exp_idx, input int exp_score);
        int lat;
        int bc;
        run(0, 1'b0, lat, bc);
        check({tag, "_latency"}, lat, LAT);
        check({tag, "_busy_cycles"}, bc, LAT);
        check({tag, "_done_pulse_drop"}, {31'd0, done}, 32'd0);
        check({tag, "_busy_drop"}, {31'd0, busy}, 32'd0);
        check({tag, "_class_idx"}, {30'd0, class_idx}, exp_idx);
        check({tag, "_class_score"}, {16'd0, class_score}, exp_score);
    endtask

    initial begin
        int lat;
        int bc;
        int extra_done;
        int extra_busy;

        checks = 0;
        errors = 0;
        start  = 1'b0;
        rst_n  = 1'b0;
        clear_mem();
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_class_idx", {30'd0, class_idx}, 32'd0);
        check("reset_class_score", {16'd0, class_score}, 32'd0);
        check("reset_in_addr", {30'd0, in_addr}, 32'd0);
        check("reset_w_addr", {27'd0, w_addr}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // 1: zero weights, only class 2 has a bias of 5.0.
        clear_mem();
        w_mem[ow(2, 3)] = 16'h0500;
        run_and_check("bias_only", 2, 16'h0500);

        // 2: equal scores -> lowest index wins.
        clear_mem();
        for (int o = 0; o < OUT_N; o++) w_mem[ow(o, 3)] = 16'h0100;
        run_and_check("tie", 0, 16'h0100);

        // 3: hidden 4.0-6.0 = -2.0 clipped by ReLU; scores equal the biases.
        clear_mem();
        for (int i = 0; i < IN_SIZE; i++) in_mem[i] = 16'h0100;
        for (int h = 0; h < HID_N; h++) begin
            for (int i = 0; i < IN_SIZE; i++) w_mem[hw(h, i)] = 16'h0100;
            w_mem[hw(h, IN_SIZE)] = 16'hFA00;
        end
        for (int o = 0; o < OUT_N; o++) begin
            for (int j = 0; j < HID_N; j++) w_mem[ow(o, j)] = 16'h0100;
            w_mem[ow(o, 3)] = 16'((o + 1) * 256);
        end
        run_and_check("relu", 2, 16'h0300);

        // 4: negative scores {-2,-1,-3}: signed compare picks class 1.
        clear_mem();
        w_mem[ow(0, 3)] = 16'hFE00;
        w_mem[ow(1, 3)] = 16'hFF00;
        w_mem[ow(2, 3)] = 16'hFD00;
        run_and_check("negative", 1, 16'hFF00);

        // 5: distinct operands. Hidden = {1.0, 2.0, 0.5};
        //    class0 = 1.0, class1 = 2.0, class2 = -0.5 + 3.0 = 2.5.
        clear_mem();
        in_mem[0] = 16'h0100;
        in_mem[1] = 16'h0200;
        w_mem[hw(0, 0)] = 16'h0100;
        w_mem[hw(1, 1)] = 16'h0100;
        w_mem[hw(2, IN_SIZE)] = 16'h0080;
        w_mem[ow(0, 0)] = 16'h0100;
        w_mem[ow(1, 1)] = 16'h0100;
        w_mem[ow(2, 2)] = 16'hFF00;
        w_mem[ow(2, 3)] = 16'h0300;
        run_and_check("operand_order", 2, 16'h0280);

        // 6: saturation in both layers; class 1 only has non-zero weights.
        clear_mem();
        for (int i = 0; i < IN_SIZE; i++) in_mem[i] = 16'h7FFF;
        for (int h = 0; h < HID_N; h++)
            for (int i = 0; i < IN_SIZE; i++) w_mem[hw(h, i)] = 16'h7FFF;
        for (int j = 0; j < HID_N; j++) w_mem[ow(1, j)] = 16'h0100;
        run_and_check("saturate", 1, 16'h7FFF);

        // 7: start at cycle 5 and on the done cycle are both ignored.
        run(5, 1'b1, lat, bc);
        check("ignore_start_latency", lat, LAT);
        check("ignore_start_busy_cycles", bc, LAT);
        extra_done = 0;
        extra_busy = 0;
        for (int k = 0; k < 60; k++) begin
            if (done) extra_done++;
            if (busy) extra_busy++;
            @(posedge clk);
            #1;
        end
        check("ignore_start_no_extra_done", extra_done, 0);
        check("ignore_start_no_restart", extra_busy, 0);
        check("ignore_start_class_idx", {30'd0, class_idx}, 32'd1);

        // 8: async reset mid-run, then a clean rerun.
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset_busy", {31'd0, busy}, 32'd0);
        check("midreset_done", {31'd0, done}, 32'd0);
        check("midreset_class_idx", {30'd0, class_idx}, 32'd0);
        check("midreset_class_score", {16'd0, class_score}, 32'd0);
        check("midreset_in_addr", {30'd0, in_addr}, 32'd0);
        check("midreset_w_addr", {27'd0, w_addr}, 32'd0);
        extra_done = 0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            if (done) extra_done++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(posedge clk);
            #1;
            if (done) extra_done++;
        end
        check("midreset_no_done", extra_done, 0);
        run_and_check("after_reset", 1, 16'h7FFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mlp_seq_classifier.md
Name: mlp_seq_classifier

Overview:
- Parametrised, time-multiplexed successor to the parallel two-layer digit classifier.
- Uses one signed MAC, shared sequentially across all hidden and output neurons.
- Reads input pixels and weights/biases from external synchronous memories and buffers the hidden activations internally.
- Ends with an iterative argmax that emits the class index, its score and a done pulse.

Parameters:
- IN_SIZE, 784, input vector length.
- HID_N, 10, hidden-layer neurons.
- OUT_N, 10, output-layer neurons (classes).
- DW, 16, signed data/weight width.
- FRAC, 8, fractional bits of the fixed-point format (Q(DW-FRAC).FRAC).
- ACC_W, 40, signed accumulator width.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begins one classification; accepted only in IDLE.
- in_addr  out  $clog2(IN_SIZE)  input-buffer read address.
- in_data  in  DW  signed pixel; valid 1 cycle after in_addr.
- w_addr  out  $clog2(HID_N*(IN_SIZE+1)+OUT_N*(HID_N+1))  weight-memory read address.
- w_data  in  DW  signed weight/bias; valid 1 cycle after w_addr.
- busy  out  1  high from start acceptance until the done cycle, inclusive.
- done  out  1  one-cycle completion pulse.
- class_idx  out  $clog2(OUT_N)  winning class.
- class_score  out  DW  winning score.

Behaviour:
- Reset (async, any state): FSM goes to IDLE. busy=0, done=0, class_idx=0, class_score=0, in_addr=0, w_addr=0. Accumulator and hidden buffer are cleared.
- Weight-memory layout:
  - Hidden neuron h: weight i at h*(IN_SIZE+1)+i; bias at h*(IN_SIZE+1)+IN_SIZE.
  - Output base OB=HID_N*(IN_SIZE+1). Output neuron o: weight j at OB+o*(HID_N+1)+j; bias at OB+o*(HID_N+1)+HID_N.
- FSM states: IDLE, H_MAC, H_DRAIN, H_WB, O_MAC, O_DRAIN, O_WB, ARGMAX, DONE.
- Per neuron with N inputs (N=IN_SIZE for hidden, N=HID_N for output):
  - MAC state lasts N+1 cycles. Cycles 0..N-1 issue weight/operand addresses; cycle N issues the bias address.
  - Data returns one cycle later and is accumulated: acc += x*w using the full 2*DW signed product.
  - DRAIN (1 cycle) accumulates the bias as w_data<<<FRAC.
  - WB (1 cycle) computes r = acc>>>FRAC (arithmetic shift), saturated to signed DW (max 0x7FFF, min 0x8000 at DW=16).
  - Hidden neurons store max(r,0) (ReLU); output neurons store r unclipped.
  - The accumulator clears at the start of each neuron.
  - Total per neuron: N+3 cycles.
- Output-layer operands come from the internal hidden buffer, read combinationally, aligned with the 1-cycle w_data latency.
- ARGMAX takes OUT_N cycles, scanning scores 0..OUT_N-1. It replaces the running best only on a strict signed greater-than, so ties resolve to the lowest index.
- DONE (1 cycle): done=1, class_idx and class_score update, then the FSM returns to IDLE.
- class_idx and class_score hold until the next DONE or reset.
- Latency from the cycle start is accepted to the done cycle: L = HID_N*(IN_SIZE+3) + OUT_N*(HID_N+3) + OUT_N + 1.
- start outside IDLE (including the DONE cycle) is ignored with no side effects.
- in_addr and w_addr hold their last value when not issuing.
- in_data and w_data are assumed stable only in the cycle after their address; the block never reuses them later.

Test Plan (IN_SIZE=4, HID_N=3, OUT_N=3, DW=16, FRAC=8; L=43):
- All weights 0; output biases {0x0000,0x0000,0x0500}; pulse start -> done exactly 43 cycles later, class_idx=2, class_score=0x0500, busy high 43 cycles.
- All output biases 0x0100, all other weights 0 -> tie; class_idx=0, class_score=0x0100.
- Inputs 0x0100, hidden weights 0x0100, hidden biases 0xFA00 (-6.0); output weights 0x0100, output biases {1,2,3}.0 -> hidden 4.0-6.0 ReLU'd to 0; scores equal biases; class_idx=2, class_score=0x0300.
- Inputs and hidden weights 0x7FFF, hidden biases 0, output weights 0x0100 for class 1 only -> hidden saturates to 0x7FFF; class 1 score saturates 0x7FFF; class_idx=1.
- Assert start at cycle 5 and on the DONE cycle of a run -> both ignored; exactly one done at cycle 43.
- Assert rst_n low at cycle 10 of a run -> outputs take reset values immediately and no done. Start again after release -> full 43-cycle run with correct result.
